// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: turns valid/ready commands into single-outstanding AHB SINGLE NONSEQ transfers,
// with a data-phase wait timeout and bounded RETRY/SPLIT re-issue.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// ADDR  | address phase driven (hsel, NONSEQ) until hready
// DATA  | data phase: wait, complete, re-issue on RETRY/SPLIT, or time out
// RESP  | response held on rsp_* until rsp_ready
module ahb_cmd_master #(
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        hsel,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic [1:0]  hresp
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam int WAIT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT);

  state_t             state;
  logic [WAIT_W-1:0]  wait_left;
  logic [RETRY_W-1:0] retry_cnt;
  logic [31:0]        wdata_q;
  logic               cmd_legal;

  always_comb begin
    cmd_legal = 1'b0;
    case (cmd_size)
      3'd0:    cmd_legal = 1'b1;
      3'd1:    cmd_legal = ~cmd_addr[0];
      3'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
      default: cmd_legal = 1'b0;
    endcase
  end

  assign hburst = 3'b000;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      hsel        <= 1'b0;
      htrans      <= HTRANS_IDLE;
      haddr       <= '0;
      hwrite      <= 1'b0;
      hsize       <= 3'b010;
      hwdata      <= '0;
      wdata_q     <= '0;
      wait_left   <= '0;
      retry_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            retry_cnt <= '0;
            if (cmd_legal) begin
              haddr     <= cmd_addr;
              hwrite    <= cmd_write;
              hsize     <= cmd_size;
              wdata_q   <= cmd_wdata;
              hsel      <= 1'b1;
              htrans    <= HTRANS_NONSEQ;
              wait_left <= WAIT_LOAD;
              state     <= S_ADDR;
            end else begin
              // illegal size/alignment is answered without touching the bus
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (hready) begin
            hsel   <= 1'b0;
            htrans <= HTRANS_IDLE;
            hwdata <= hwrite ? wdata_q : 32'h0;
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (hresp[1]) begin
            // RETRY/SPLIT acted on in its first (hready low) cycle
            hwdata <= '0;
            if (int'(retry_cnt) < MAX_RETRY) begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
              hsel      <= 1'b1;
              htrans    <= HTRANS_NONSEQ;
              wait_left <= WAIT_LOAD;
              state     <= S_ADDR;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= S_RESP;
            end
          end else if (hready) begin
            hwdata    <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= hresp[0];
            rsp_rdata <= (!hresp[0] && !hwrite) ? hrdata : 32'h0;
            state     <= S_RESP;
          end else if (TIMEOUT != 0) begin
            if (wait_left == WAIT_W'(1)) begin
              hwdata      <= '0;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_rdata   <= '0;
              state       <= S_RESP;
            end else begin
              wait_left <= wait_left - WAIT_W'(1);
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            cmd_ready   <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master: drives commands into ahb_cmd_master against a behavioural AHB slave and a
// byte-array memory model; each scenario task checks responses, latency and bus activity.
module tb_ahb_cmd_master;

  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 3;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;
  logic        hready;

  ahb_cmd_master #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_nonseq = 0;
  int n_hsel = 0;
  int n_bad = 0;
  int hold_bad = 0;
  int busy_bad = 0;

  localparam logic [109:0] RESET_VEC = {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                                        2'b00, 3'b010, 3'b000, 32'h0};

  function automatic logic [109:0] out_vec();
    return {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, hsel, haddr, hwrite,
            htrans, hsize, hburst, hwdata};
  endfunction

  // bus monitors
  always @(posedge hclk) begin
    cyc <= cyc + 1;
    if (hresetn && hsel && htrans == 2'b10) n_nonseq <= n_nonseq + 1;
    if (hresetn && hsel) n_hsel <= n_hsel + 1;
    if (hresetn && (hburst != 3'b000 || htrans == 2'b01 || htrans == 2'b11 ||
                    (hsel != (htrans == 2'b10))))
      n_bad <= n_bad + 1;
  end

  // ---------------- reference memory (byte array) ----------------
  logic [7:0] model_mem [0:63];

  function automatic void model_write(input int a, input int s, input logic [31:0] d);
    for (int i = 0; i < (1 << s); i++) model_mem[a + i] = d[8 * ((a + i) % 4) +: 8];
  endfunction

  function automatic logic [31:0] model_word(input int a);
    int b;
    b = a - (a % 4);
    return {model_mem[b + 3], model_mem[b + 2], model_mem[b + 1], model_mem[b]};
  endfunction

  // ---------------- behavioural AHB slave ----------------
  logic [31:0] sl_mem [0:15];
  int   sl_wait = 0;
  int   sl_retry = 0;
  logic sl_err = 1'b0;
  logic sl_hang = 1'b0;

  task automatic slave_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    logic [3:0] lanes;
    case (s)
      3'd0:    lanes = 4'b0001 << a[1:0];
      3'd1:    lanes = 4'b0011 << a[1:0];
      default: lanes = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++)
      if (lanes[b]) sl_mem[a[5:2]][8 * b +: 8] = d[8 * b +: 8];
  endtask

  task automatic slave_xfer();
    logic [31:0] a;
    logic        w;
    logic [2:0]  s;
    a = haddr; w = hwrite; s = hsize;
    @(negedge hclk);
    if (!hresetn) return;
    if (sl_retry > 0) begin
      sl_retry--;
      hready = 1'b0; hresp = 2'b10;
      @(negedge hclk);
      hready = 1'b1; hresp = 2'b10;
      return;
    end
    if (sl_hang) begin
      while (sl_hang) begin
        hready = 1'b0; hresp = 2'b00;
        @(negedge hclk);
      end
      hready = 1'b1;
      return;
    end
    for (int i = 0; i < sl_wait; i++) begin
      hready = 1'b0; hresp = 2'b00;
      @(negedge hclk);
    end
    if (sl_err) begin
      hready = 1'b0; hresp = 2'b01;
      @(negedge hclk);
      hready = 1'b1; hresp = 2'b01;
      return;
    end
    hready = 1'b1; hresp = 2'b00;
    if (w) slave_write(a, s, hwdata);
    else hrdata = sl_mem[a[5:2]];
  endtask

  initial begin
    hready = 1'b1; hresp = 2'b00; hrdata = 32'h0;
    forever begin
      @(negedge hclk);
      hready = 1'b1; hresp = 2'b00;
      while (hresetn && hsel && htrans == 2'b10) slave_xfer();
    end
  end

  // ---------------- command driver ----------------
  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d, input int rdly,
                        output logic [31:0] rd, output logic er, output logic to,
                        output int lat, output int acc);
    int n;
    rd = 32'h0; er = 1'b0; to = 1'b0; lat = -1; acc = -1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge hclk); n++; end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL accept_bound: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge hclk); #1;
    acc = cyc;
    lat = 0;
    do begin
      @(negedge hclk);
      lat++;
      if (lat == 1) cmd_valid = 1'b0;
      if (cmd_ready) busy_bad++;
    end while (!rsp_valid && lat < 200);
    if (!rsp_valid) begin
      checks++; failures++;
      $display("FAIL response_bound: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
      lat = -1;
      return;
    end
    rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
    repeat (rdly) begin
      @(negedge hclk);
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || rsp_timeout !== to) hold_bad++;
    end
    rsp_ready = 1'b1;
    @(posedge hclk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_outputs: got %h required %h", out_vec(), RESET_VEC);
    end
    @(negedge hclk); hresetn = 1'b1;
    @(negedge hclk);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_release_outputs: got %h required %h", out_vec(), RESET_VEC);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er, to; int lat, acc, na;
    do_cmd(1'b1, 32'h4, 3'd2, 32'h2, 0, rd, er, to, lat, acc);
    model_write(4, 2, 32'h2);
    checks++;
    if (er !== 1'b0 || lat != 3) begin
      failures++;
      $display("FAIL basic_write: err=%b lat=%0d required err=0 lat=3", er, lat);
    end
    na = n_nonseq;
    do_cmd(1'b0, 32'h4, 3'd2, 32'h0, 1, rd, er, to, lat, acc);
    checks++;
    if (rd !== 32'h2) begin failures++; $display("FAIL basic_rdata: got %h required 00000002", rd); end
    checks++;
    if (er !== 1'b0 || to !== 1'b0) begin
      failures++; $display("FAIL basic_status: err=%b tmo=%b required 0 0", er, to);
    end
    checks++;
    if (lat != 3) begin failures++; $display("FAIL basic_latency: got %0d required 3", lat); end
    checks++;
    if (n_nonseq - na != 1) begin
      failures++; $display("FAIL basic_nonseq_cycles: got %0d required 1", n_nonseq - na);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] rd; logic er, to; int lat, acc;
    int          ra [4] = '{4, 8, 12, 0};
    logic [31:0] rx [4] = '{32'h2, 32'h3, 32'h4, 32'h1};
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, 32'(4 * i), 3'd2, 32'(i + 1), 0, rd, er, to, lat, acc);
      model_write(4 * i, 2, 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, 32'(ra[i]), 3'd2, 32'h0, 0, rd, er, to, lat, acc);
      checks++;
      if (rd !== rx[i] || er !== 1'b0) begin
        failures++;
        $display("FAIL seq_read_%0d: got %h err=%b required %h err=0", ra[i], rd, er, rx[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er, to; int lat, acc;
    sl_wait = 5;
    do_cmd(1'b0, 32'h4, 3'd2, 32'h0, 0, rd, er, to, lat, acc);
    checks++;
    if (rd !== model_word(4) || er !== 1'b0 || lat != 8) begin
      failures++;
      $display("FAIL wait5_read: got %h err=%b lat=%0d required %h err=0 lat=8",
               rd, er, lat, model_word(4));
    end
    sl_wait = TIMEOUT - 1;
    do_cmd(1'b0, 32'h8, 3'd2, 32'h0, 0, rd, er, to, lat, acc);
    checks++;
    if (rd !== model_word(8) || er !== 1'b0 || to !== 1'b0 || lat != TIMEOUT + 2) begin
      failures++;
      $display("FAIL wait15_read: got %h err=%b tmo=%b lat=%0d required %h 0 0 lat=%0d",
               rd, er, to, lat, model_word(8), TIMEOUT + 2);
    end
    sl_wait = 0;
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er, to; int lat, acc, na;
    sl_hang = 1'b1;
    na = n_nonseq;
    do_cmd(1'b0, 32'hC, 3'd2, 32'h0, 0, rd, er, to, lat, acc);
    checks++;
    if (er !== 1'b1 || to !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL timeout_status: err=%b tmo=%b rdata=%h required 1 1 00000000", er, to, rd);
    end
    checks++;
    if (lat != TIMEOUT + 2) begin
      failures++; $display("FAIL timeout_latency: got %0d required %0d", lat, TIMEOUT + 2);
    end
    checks++;
    if (n_nonseq - na != 1) begin
      failures++; $display("FAIL timeout_nonseq_cycles: got %0d required 1", n_nonseq - na);
    end
    sl_hang = 1'b0;
    repeat (3) @(negedge hclk);
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er, to; int lat, acc, nw;
    for (int k = 0; k < 3; k++) begin
      nw = $urandom_range(0, 3);
      sl_err = 1'b1; sl_wait = nw;
      do_cmd(k[0] ? 1'b0 : 1'b1, 32'h10, 3'd2, $urandom, 0, rd, er, to, lat, acc);
      checks++;
      if (er !== 1'b1 || to !== 1'b0 || rd !== 32'h0 || lat != nw + 4) begin
        failures++;
        $display("FAIL error_resp_%0d: err=%b tmo=%b rdata=%h lat=%0d required 1 0 0 lat=%0d",
                 k, er, to, rd, lat, nw + 4);
      end
    end
    sl_err = 1'b0; sl_wait = 0;
    do_cmd(1'b0, 32'h10, 3'd2, 32'h0, 0, rd, er, to, lat, acc);
    checks++;
    if (rd !== model_word(16) || er !== 1'b0) begin
      failures++;
      $display("FAIL error_no_write: got %h err=%b required %h err=0", rd, er, model_word(16));
    end
  endtask

  task automatic test_retry();
    logic [31:0] rd; logic er, to; int lat, acc, na;
    sl_retry = 10;
    na = n_nonseq;
    do_cmd(1'b0, 32'hC, 3'd2, 32'h0, 0, rd, er, to, lat, acc);
    checks++;
    if (er !== 1'b1 || to !== 1'b0 || lat != 2 * (MAX_RETRY + 1) + 1) begin
      failures++;
      $display("FAIL retry_exhaust: err=%b tmo=%b lat=%0d required 1 0 lat=%0d",
               er, to, lat, 2 * (MAX_RETRY + 1) + 1);
    end
    checks++;
    if (n_nonseq - na != MAX_RETRY + 1) begin
      failures++;
      $display("FAIL retry_reissues: got %0d address phases required %0d", n_nonseq - na, MAX_RETRY + 1);
    end
    for (int k = 2; k <= MAX_RETRY; k++) begin
      sl_retry = k;
      na = n_nonseq;
      do_cmd(1'b0, 32'hC, 3'd2, 32'h0, 0, rd, er, to, lat, acc);
      checks++;
      if (rd !== model_word(12) || er !== 1'b0 || lat != 3 + 2 * k || n_nonseq - na != k + 1) begin
        failures++;
        $display("FAIL retry_%0d_recover: got %h err=%b lat=%0d addr=%0d required %h 0 lat=%0d addr=%0d",
                 k, rd, er, lat, n_nonseq - na, model_word(12), 3 + 2 * k, k + 1);
      end
    end
    sl_retry = 0;
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic er, to; int lat, acc, nh;
    logic [31:0] ia [3] = '{32'h2, 32'h1, 32'h0};
    logic [2:0]  is [3] = '{3'd2, 3'd1, 3'd3};
    nh = n_hsel;
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b0, ia[i], is[i], 32'h0, 0, rd, er, to, lat, acc);
      checks++;
      if (er !== 1'b1 || to !== 1'b0 || rd !== 32'h0 || lat != 1) begin
        failures++;
        $display("FAIL illegal_%0d: err=%b tmo=%b rdata=%h lat=%0d required 1 0 0 lat=1",
                 i, er, to, rd, lat);
      end
    end
    checks++;
    if (n_hsel != nh) begin failures++; $display("FAIL illegal_hsel: got %0d cycles required 0", n_hsel - nh); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er, to; int lat, acc0, acc1, acc2;
    do_cmd(1'b1, 32'h20, 3'd2, 32'hA5A5_0001, 0, rd, er, to, lat, acc0);
    model_write(32, 2, 32'hA5A5_0001);
    do_cmd(1'b0, 32'h20, 3'd2, 32'h0, 0, rd, er, to, lat, acc1);
    do_cmd(1'b0, 32'h4, 3'd2, 32'h0, 0, rd, er, to, lat, acc2);
    checks++;
    if (acc1 - acc0 != 4 || acc2 - acc1 != 4) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d,%0d cycles required 4,4", acc1 - acc0, acc2 - acc1);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, a; logic er, to, w, bad, e; logic [2:0] s; int lat, acc, nw, elat;
    for (int it = 0; it < 60; it++) begin
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      nw = $urandom_range(0, 3);
      e  = ($urandom_range(0, 9) == 0);
      bad = ($urandom_range(0, 9) == 0);
      if (bad) begin
        s = 3'($urandom_range(1, 7));
        a = 32'($urandom_range(0, 15) * 4 + 1);
      end else begin
        s = 3'($urandom_range(0, 2));
        a = 32'($urandom_range(0, 63)) & ~((32'h1 << s) - 32'h1);
      end
      sl_wait = nw; sl_err = e;
      do_cmd(w, a, s, d, $urandom_range(0, 2), rd, er, to, lat, acc);
      if (bad)    elat = 1;
      else if (e) elat = nw + 4;
      else        elat = nw + 3;
      if (!bad && !e && w) model_write(int'(a), int'(s), d);
      checks++;
      if (er !== (bad || e) || to !== 1'b0 || lat != elat ||
          rd !== ((bad || e || w) ? 32'h0 : model_word(int'(a)))) begin
        failures++;
        $display("FAIL random_%0d: w=%b a=%h s=%0d got %h err=%b tmo=%b lat=%0d required %h err=%b lat=%0d",
                 it, w, a, s, rd, er, to, lat,
                 (bad || e || w) ? 32'h0 : model_word(int'(a)), bad || e, elat);
      end
    end
    sl_wait = 0; sl_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, to; int lat, acc, n, seen;
    sl_hang = 1'b1;
    cmd_write = 1'b0; cmd_addr = 32'd21; cmd_size = 3'd0; cmd_wdata = 32'h0; cmd_valid = 1'b1;
    n = 0;
    while (!hsel && n < 20) begin @(negedge hclk); n++; end
    cmd_valid = 1'b0;
    @(negedge hclk);
    checks++;
    if (hsel !== 1'b0 || hsize !== 3'd0 || haddr !== 32'd21) begin
      failures++;
      $display("FAIL midreset_setup: hsel=%b hsize=%0d haddr=%h required 0 0 00000015", hsel, hsize, haddr);
    end
    #2 hresetn = 1'b0;
    #1;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL midreset_outputs: got %h required %h", out_vec(), RESET_VEC);
    end
    sl_hang = 1'b0;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge hclk); if (rsp_valid) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midreset_no_resp: rsp_valid seen %0d cycles required 0", seen); end
    do_cmd(1'b0, 32'h0, 3'd2, 32'h0, 0, rd, er, to, lat, acc);
    checks++;
    if (rd !== model_word(0) || er !== 1'b0 || lat != 3) begin
      failures++;
      $display("FAIL midreset_recover: got %h err=%b lat=%0d required %h 0 lat=3", rd, er, lat, model_word(0));
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (n_bad != 0) begin failures++; $display("FAIL bus_encoding: %0d bad cycles required 0", n_bad); end
    checks++;
    if (hold_bad != 0) begin failures++; $display("FAIL rsp_hold: %0d unstable cycles required 0", hold_bad); end
    checks++;
    if (busy_bad != 0) begin failures++; $display("FAIL cmd_ready_busy: %0d cycles high required 0", busy_bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) sl_mem[i] = 32'h0;
    hresetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_sequence();
    test_wait_states();
    test_timeout();
    test_error();
    test_retry();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
